// File: rtl/a2600_pkg.sv
// Shared types for the 2600 cartridge loader.
// Bank-switch codes and file-extension decode.
package a2600_pkg;

  localparam int ROM_AW = 15;

  typedef enum logic [3:0] {
    BS_AUTO = 4'd0,
    BS_F8   = 4'd1,
    BS_F6   = 4'd2,
    BS_FE   = 4'd3,
    BS_E0   = 4'd4,
    BS_3F   = 4'd5,
    BS_F4   = 4'd6,
    BS_P2   = 4'd7,
    BS_FA   = 4'd8,
    BS_CV   = 4'd9
  } bs_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_SETTLE
  } ld_st_t;

  // Keys carry the leading dot so a bare 3-char ext never matches.
  function automatic bs_t ext_to_bs(input logic [23:0] ext);
    bs_t bs;
    bs = BS_AUTO;
    unique case (1'b1)
      ext == 24'h2E4638: bs = BS_F8;
      ext == 24'h2E4636: bs = BS_F6;
      ext == 24'h2E4645: bs = BS_FE;
      ext == 24'h2E4530: bs = BS_E0;
      ext == 24'h2E3346: bs = BS_3F;
      ext == 24'h2E4634: bs = BS_F4;
      ext == 24'h2E5032: bs = BS_P2;
      ext == 24'h2E4641: bs = BS_FA;
      ext == 24'h2E4356: bs = BS_CV;
      default:           bs = BS_AUTO;
    endcase
    return bs;
  endfunction

endpackage

// File: rtl/cart_load_ctrl.sv
// Cartridge download sequencer: ROM writes, config latch,
// size tracking and core reset hold.
module cart_load_ctrl
  import a2600_pkg::*;
#(
  parameter int AW         = ROM_AW,
  parameter int SETTLE_CYC = 64
) (
  input  logic          clk_sys,
  input  logic          reset,
  input  logic          ioctl_download,
  input  logic          ioctl_wr,
  input  logic [24:0]   ioctl_addr,
  input  logic [7:0]    ioctl_dout,
  input  logic [31:0]   ioctl_file_ext,
  input  logic [1:0]    sc_mode,
  output logic          rom_we,
  output logic [AW-1:0] rom_waddr,
  output logic [7:0]    rom_wdata,
  output logic [16:0]   rom_size,
  output logic [3:0]    force_bs,
  output logic          sc,
  output logic          core_reset,
  output logic          load_err
);

  localparam int CW = $clog2(SETTLE_CYC) + 1;

  ld_st_t        state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic          prev;
  logic          boot;
  logic          rise;
  logic          latch;
  logic          in_range;
  logic          wr_ok;
  logic          wr_err;
  logic          core_reset_d;
  logic [16:0]   sz_new;
  logic [23:0]   ext;
  bs_t           bs_q;

  assign rise     = ioctl_download & ~prev;
  assign in_range = (ioctl_addr[24:AW] == '0);
  assign wr_ok    = (state == S_LOAD) & ioctl_wr & in_range;
  assign wr_err   = (state == S_LOAD) & ioctl_wr & ~in_range;
  assign latch    = (state_nx == S_LOAD) & (state != S_LOAD);
  assign sz_new   = 17'(ioctl_addr[AW-1:0]) + 17'd1;
  assign ext      = (ioctl_file_ext[23:16] == 8'h2E) ?
                    ioctl_file_ext[23:0] : ioctl_file_ext[31:8];
  assign force_bs = bs_q;

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state <= S_IDLE;
      cnt   <= '0;
      prev  <= 1'b0;
      boot  <= 1'b1;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      prev  <= ioctl_download;
      if (state_nx != S_IDLE) boot <= 1'b0;
    end
  end

  // Boot flag routes the first post-reset idle through SETTLE.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    unique case (state)
      S_IDLE: begin
        if (rise) begin
          state_nx = S_LOAD;
        end else if (boot) begin
          state_nx = S_SETTLE;
          cnt_nx   = CW'(SETTLE_CYC - 1);
        end
      end
      S_LOAD: begin
        if (!ioctl_download) begin
          state_nx = S_SETTLE;
          cnt_nx   = CW'(SETTLE_CYC - 1);
        end
      end
      S_SETTLE: begin
        if (rise) begin
          state_nx = S_LOAD;
        end else if (cnt == '0) begin
          state_nx = S_IDLE;
        end else begin
          cnt_nx = cnt - 1'b1;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    core_reset_d = (state_nx != S_IDLE);
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      core_reset <= 1'b1;
      rom_we     <= 1'b0;
      rom_waddr  <= '0;
      rom_wdata  <= '0;
      rom_size   <= '0;
      bs_q       <= BS_AUTO;
      sc         <= 1'b0;
      load_err   <= 1'b0;
    end else begin
      core_reset <= core_reset_d;
      rom_we     <= wr_ok;
      if (wr_ok) begin
        rom_waddr <= ioctl_addr[AW-1:0];
        rom_wdata <= ioctl_dout;
      end
      if (latch) begin
        bs_q     <= ext_to_bs(ext);
        sc       <= (sc_mode == 2'd0) ?
                    (ioctl_file_ext[7:0] == 8'h53) : sc_mode[1];
        rom_size <= '0;
        load_err <= 1'b0;
      end else begin
        if (wr_ok && sz_new > rom_size) rom_size <= sz_new;
        if (wr_err) load_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_cart_load_ctrl.sv
// Directed bench for cart_load_ctrl: table of extension
// vectors plus overflow, back-to-back and reset-abort cases.
module tb_cart_load_ctrl;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic        ioctl_download;
  logic        ioctl_wr;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout;
  logic [31:0] ioctl_file_ext;
  logic [1:0]  sc_mode;
  logic        rom_we;
  logic [14:0] rom_waddr;
  logic [7:0]  rom_wdata;
  logic [16:0] rom_size;
  logic [3:0]  force_bs;
  logic        sc;
  logic        core_reset;
  logic        load_err;

  int checks   = 0;
  int failures = 0;

  always #5 clk_sys = ~clk_sys;

  cart_load_ctrl #(.AW(15), .SETTLE_CYC(64)) dut (
    .clk_sys        (clk_sys),
    .reset          (reset),
    .ioctl_download (ioctl_download),
    .ioctl_wr       (ioctl_wr),
    .ioctl_addr     (ioctl_addr),
    .ioctl_dout     (ioctl_dout),
    .ioctl_file_ext (ioctl_file_ext),
    .sc_mode        (sc_mode),
    .rom_we         (rom_we),
    .rom_waddr      (rom_waddr),
    .rom_wdata      (rom_wdata),
    .rom_size       (rom_size),
    .force_bs       (force_bs),
    .sc             (sc),
    .core_reset     (core_reset),
    .load_err       (load_err)
  );

  typedef struct {
    logic [31:0] ext;
    logic [1:0]  scm;
    int          n;
    logic [3:0]  bs;
    logic        sc;
  } vec_t;

  vec_t vt[7];

  function automatic logic [7:0] pat(input int i);
    return 8'(i) ^ 8'(i >> 8) ^ 8'h5A;
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk_sys);
    #1;
  endtask

  task automatic wait_core(output int n);
    n = 0;
    while (core_reset === 1'b1 && n < 300) begin
      tick();
      n++;
    end
  endtask

  task automatic load(input logic [31:0] ext, input logic [1:0] scm,
                      input int n, output int werr, output int crc);
    werr = 0;
    ioctl_file_ext = ext;
    sc_mode = scm;
    ioctl_download = 1'b1;
    ioctl_wr = 1'b0;
    tick();
    for (int i = 0; i < n; i++) begin
      ioctl_wr = 1'b1;
      ioctl_addr = 25'(i);
      ioctl_dout = pat(i);
      if (i == n - 1) ioctl_download = 1'b0;
      tick();
      if (i < 32768) begin
        if (rom_we !== 1'b1 || rom_waddr !== 15'(i) ||
            rom_wdata !== pat(i)) werr++;
      end else if (rom_we !== 1'b0) begin
        werr++;
      end
      if (core_reset !== 1'b1) werr++;
    end
    ioctl_wr = 1'b0;
    ioctl_download = 1'b0;
    wait_core(crc);
  endtask

  initial begin
    int werr;
    int crc;

    vt[0] = '{32'h002E4638, 2'd0, 4096, 4'd1, 1'b0};
    vt[1] = '{32'h00413236, 2'd0, 20,   4'd0, 1'b0};
    vt[2] = '{32'h00463853, 2'd0, 21,   4'd0, 1'b1};
    vt[3] = '{32'h00463853, 2'd1, 22,   4'd0, 1'b0};
    vt[4] = '{32'h002E4636, 2'd2, 23,   4'd2, 1'b1};
    vt[5] = '{32'h002E4356, 2'd3, 24,   4'd9, 1'b1};
    vt[6] = '{32'h002E5032, 2'd0, 25,   4'd7, 1'b0};

    reset = 1'b1;
    ioctl_download = 1'b0;
    ioctl_wr = 1'b0;
    ioctl_addr = '0;
    ioctl_dout = '0;
    ioctl_file_ext = '0;
    sc_mode = 2'd0;
    repeat (3) tick();
    chk("rst_rom_we", 32'(rom_we), 0);
    chk("rst_core_reset", 32'(core_reset), 1);
    chk("rst_rom_size", 32'(rom_size), 0);
    chk("rst_force_bs", 32'(force_bs), 0);
    chk("rst_sc_err", {30'd0, sc, load_err}, 0);

    reset = 1'b0;
    wait_core(crc);
    checks++;
    if (crc < 64 || crc > 66) begin
      failures++;
      $display("FAIL boot_settle actual=%0d required=64..66", crc);
    end

    foreach (vt[k]) begin
      load(vt[k].ext, vt[k].scm, vt[k].n, werr, crc);
      chk($sformatf("v%0d_force_bs", k), 32'(force_bs), 32'(vt[k].bs));
      chk($sformatf("v%0d_sc", k), 32'(sc), 32'(vt[k].sc));
      chk($sformatf("v%0d_rom_size", k), 32'(rom_size), 32'(vt[k].n));
      chk($sformatf("v%0d_wr_errs", k), 32'(werr), 0);
      chk($sformatf("v%0d_settle", k), 32'(crc), 64);
      chk($sformatf("v%0d_load_err", k), 32'(load_err), 0);
    end

    load(32'h002E4645, 2'd0, 32770, werr, crc);
    chk("ovf_wr_errs", 32'(werr), 0);
    chk("ovf_load_err", 32'(load_err), 1);
    chk("ovf_rom_size", 32'(rom_size), 32768);
    chk("ovf_force_bs", 32'(force_bs), 3);

    load(32'h002E4530, 2'd0, 2048, werr, crc);
    chk("k2_load_err", 32'(load_err), 0);
    chk("k2_rom_size", 32'(rom_size), 2048);
    chk("k2_force_bs", 32'(force_bs), 4);
    chk("k2_wr_errs", 32'(werr), 0);

    ioctl_wr = 1'b1;
    ioctl_addr = 25'd5;
    tick();
    ioctl_wr = 1'b0;
    chk("idle_wr_ignored", 32'(rom_we), 0);
    chk("idle_size_kept", 32'(rom_size), 2048);

    ioctl_file_ext = 32'h002E4636;
    sc_mode = 2'd2;
    ioctl_download = 1'b1;
    tick();
    for (int i = 0; i < 100; i++) begin
      ioctl_wr = 1'b1;
      ioctl_addr = 25'(i);
      ioctl_dout = pat(i);
      tick();
    end
    chk("mid_rom_size", 32'(rom_size), 100);
    chk("mid_force_bs", 32'(force_bs), 2);
    reset = 1'b1;
    ioctl_addr = 25'd100;
    ioctl_file_ext = 32'h002E4645;
    sc_mode = 2'd0;
    tick();
    chk("abort_rom_we", 32'(rom_we), 0);
    chk("abort_rom_size", 32'(rom_size), 0);
    chk("abort_force_bs", 32'(force_bs), 0);
    chk("abort_sc", 32'(sc), 0);
    chk("abort_core_reset", 32'(core_reset), 1);
    chk("abort_waddr", 32'(rom_waddr), 0);
    reset = 1'b0;
    ioctl_wr = 1'b0;
    tick();
    chk("relatch_force_bs", 32'(force_bs), 3);
    chk("relatch_core_reset", 32'(core_reset), 1);
    werr = 0;
    for (int i = 0; i < 10; i++) begin
      ioctl_wr = 1'b1;
      ioctl_addr = 25'(i);
      ioctl_dout = pat(i + 7);
      if (i == 9) ioctl_download = 1'b0;
      tick();
      if (rom_we !== 1'b1 || rom_waddr !== 15'(i) ||
          rom_wdata !== pat(i + 7)) werr++;
    end
    ioctl_wr = 1'b0;
    chk("relatch_wr_errs", 32'(werr), 0);
    chk("relatch_rom_size", 32'(rom_size), 10);
    wait_core(crc);
    chk("relatch_settle", 32'(crc), 64);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cart_load_ctrl.md
Name: cart_load_ctrl

Overview:
Sequences a cartridge download from the HPS ioctl stream into the 32 KB ROM dual-port RAM (port A). It latches the file extension to select the forced bank-switch scheme and the SuperChip enable, and measures the ROM size. It also holds the 2600 core in reset for the whole load plus a settle window. It sits between hps_io and the ROM dpram / A2601top configuration inputs, replacing loose glue logic in the top level.

Parameters:
AW, 15, ROM address width; capacity is 2**AW bytes.
SETTLE_CYC, 64, clk_sys cycles core_reset stays high after ioctl_download falls; minimum 1.

Ports:
clk_sys  in  1  system clock; all logic runs on the rising edge.
reset  in  1  synchronous, active-high; samples RESET | OSD reset | button.
ioctl_download  in  1  HPS download in progress.
ioctl_wr  in  1  one-cycle byte-valid strobe.
ioctl_addr  in  25  byte address of ioctl_dout.
ioctl_dout  in  8  download byte.
ioctl_file_ext  in  32  ASCII file extension, right-aligned.
sc_mode  in  2  0 = auto, 1 = disable, 2/3 = enable SuperChip.
rom_we  out  1  dpram port A write enable.
rom_waddr  out  AW  dpram port A address.
rom_wdata  out  8  dpram port A data.
rom_size  out  17  bytes loaded (highest accepted address + 1).
force_bs  out  4  forced bank-switch scheme; 0 = auto-detect.
sc  out  1  SuperChip RAM enable.
core_reset  out  1  reset to A2601top.
load_err  out  1  image exceeded 2**AW bytes; sticky until next load starts.

Behaviour:
- Reset values: rom_we=0, rom_waddr=0, rom_wdata=0, rom_size=0, force_bs=0, sc=0, load_err=0, core_reset=1. State goes to IDLE. The settle counter and the previous-download register clear to 0.
- After reset deasserts, core_reset stays 1 for SETTLE_CYC cycles (the block passes through SETTLE). A download held high across reset counts as a new rising edge.
- FSM:
  - IDLE: core_reset=0. A rising edge of ioctl_download (prev=0, cur=1) goes to LOAD on that cycle and latches the configuration.
  - LOAD: core_reset=1. Accept writes. Falling ioctl_download goes to SETTLE and loads the counter with SETTLE_CYC-1.
  - SETTLE: core_reset=1. Counter decrements each cycle; at 0 the FSM goes to IDLE and core_reset drops on the next cycle. A new rising edge in SETTLE goes to LOAD.
- Config latch on the rising edge, all in the same cycle:
  - ext = ioctl_file_ext[23:0] if byte [23:16]=="." else ioctl_file_ext[31:8].
  - force_bs: .F8=1, .F6=2, .FE=3, .E0=4, .3F=5, .F4=6, .P2=7, .FA=8, .CV=9, otherwise 0.
  - sc: sc_mode==0 gives (ioctl_file_ext[7:0]=="S"); otherwise sc_mode[1].
  - rom_size=0, load_err=0.
- Write path:
  - In LOAD, when ioctl_wr=1 and ioctl_addr < 2**AW: one registered cycle later rom_we=1, rom_waddr=ioctl_addr[AW-1:0], rom_wdata=ioctl_dout.
  - rom_size <= max(rom_size, ioctl_addr+1) with 17-bit arithmetic.
  - When ioctl_addr ≥ 2**AW: the write is suppressed (rom_we stays 0), load_err <= 1, rom_size unchanged.
- ioctl_wr outside LOAD is ignored. Back-to-back ioctl_wr on consecutive cycles must all be written; there is no backpressure.
- A write strobe on the same cycle as download falling is still accepted.
- Reset mid-LOAD aborts the load. Written bytes stay in RAM; outputs return to reset values.

Decomposition:
- Shared package a2600_pkg:
  - typedef bs_t (4-bit enum: BS_AUTO, BS_F8, BS_F6, BS_FE, BS_E0, BS_3F, BS_F4, BS_P2, BS_FA, BS_CV).
  - ROM_AW constant.
  - Function ext_to_bs(24-bit ext) returning bs_t.
- No sub-module is needed; the FSM, write register and size tracker stay flat.

Test Plan:
- Load 4096 bytes, ext "F8" with "." at [23:16], sc_mode=0 -> force_bs=1, sc=0, rom_size=4096.
  - Each byte appears one cycle later at rom_waddr 0..4095.
  - core_reset stays 1 through download + 64 cycles, then 0.
- Load with ext "A26", sc_mode=0, last char not 'S' -> force_bs=0, sc=0.
- Load with ext "F8S" (ioctl_file_ext[7:0]=="S"), sc_mode=0 -> force_bs=0 (not in table), sc=1.
- Repeat with sc_mode=1 -> sc=0.
- Stream 32770 bytes -> addresses 32768/32769 produce no rom_we; load_err=1; rom_size=32768.
  - A following 2 KB load clears load_err and sets rom_size=2048.
- Consecutive ioctl_wr every cycle, last strobe coincident with download falling -> every byte written, the last one included.
- Assert reset at byte 100 of a load -> outputs at reset values next cycle.
  - With download still high, the FSM re-enters LOAD and relatches force_bs.
  - rom_size counts from 0.
